dsp_mac_out_registered: RTL and testbench
=========================================

# dsp_mac_out_registered

Output-side counterpart to the input-registered DSP cells. The block takes unregistered operand pairs through a valid/ready handshake and forms a multiply or add term combinationally. It accumulates `ACC_LEN` terms, then presents the sum from an output register, with its own valid/ready handshake and an overflow flag. It sits between the operand producer and a downstream consumer in the DSP test designs, and exercises sequential output registers and handshakes in the v2x flow.

## Interface
- `DATA_WIDTH`, 4: term width; operands are `DATA_WIDTH/2` bits each.
- `ACC_WIDTH`, 8: accumulator and output width; must be ≥ `DATA_WIDTH`.
- `ACC_LEN`, 4: terms per result; must be ≥ 1.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  operand pair present.
- `in_ready`  out  1  block can accept a pair this cycle.
- `a`  in  `DATA_WIDTH/2`  operand A, unsigned.
- `b`  in  `DATA_WIDTH/2`  operand B, unsigned.
- `m`  in  1  mode: 1 = a*b, 0 = a+b.
- `clr`  in  1  synchronous discard of the partial accumulation.
- `out_valid`  out  1  result held in the output register.
- `out_ready`  in  1  consumer takes the result.
- `out`  out  `ACC_WIDTH`  registered sum.
- `ovf`  out  1  registered: the sum wrapped (or saturated) during this result.

## Operation
- Term = `m ? a*b : a+b`, computed unsigned at `DATA_WIDTH` bits, then zero-extended to `ACC_WIDTH`.
- Accept = `in_valid && in_ready`.
- States:
  - ACCUM: count < `ACC_LEN` accepts; `in_ready` = 1.
  - HOLD: `out_valid` = 1; `in_ready` = `out_ready`.
- ACCUM, on accept: acc += term and count++. On the `ACC_LEN`-th accept:
  - out = acc + term, and ovf = any overflow across the result.
  - acc and count reset to 0; state goes to HOLD.
- HOLD, on `out_ready`:
  - With a simultaneous accept: that term starts the next accumulation (acc = term, count = 1); state goes to ACCUM. If `ACC_LEN` = 1, out reloads and the state stays HOLD.
  - Without an accept: state goes to ACCUM.
- HOLD, while `out_ready` = 0: out, ovf and `out_valid` are held stable.
- Overflow: carry out of `ACC_WIDTH` sets a sticky partial-overflow bit. The bit is transferred to ovf when the result is loaded, then cleared.
- `clr`:
  - Zeroes acc, count and the sticky bit.
  - Does not affect a result already in HOLD.
  - `clr` together with an accept: acc = term, count = 1. If `ACC_LEN` = 1, the term completes a result.
- Reset (`rst_n` = 0 at an edge):
  - State goes to ACCUM; acc, count, sticky, out, ovf and `out_valid` = 0.
  - `in_ready` = 0 while `rst_n` is low.
  - A result pending mid-operation is discarded.

## Timing
- Result latency: `out_valid` rises 1 cycle after the edge of the `ACC_LEN`-th accept.
- Throughput: one term per cycle, including under back-to-back results when `out_ready` = 1.
- `in_ready` depends combinationally on state, `out_ready` and `rst_n` only, never on `in_valid`.
- Outputs are direct register outputs: `out_valid`, `out`, `ovf`.

## Configuration
- `DSP_MAC_SATURATE_EN`
  - Defined: acc clamps at 2^`ACC_WIDTH`−1 on carry, and stays there until the result loads; ovf still reports that the clamp occurred.
  - Undefined: acc wraps modulo 2^`ACC_WIDTH`.

## Structure
- Shared package `dsp_mac_pkg`:
  - State enum (ACCUM, HOLD).
  - Mode constants `DSP_MODE_ADD` = 0 and `DSP_MODE_MUL` = 1.
  - Helper for the count width, clog2(`ACC_LEN`+1).
- One sub-module, `dsp_mac_term`: the combinational term generator (a, b, m → term).
- The top level holds the FSM, accumulator, counter and output register.

## Test plan
- Multiply: defaults, four accepts of a=3, b=3, m=1, `out_ready` = 1 → `out_valid` pulses 1 cycle after the 4th accept; out = 36 (0x24), ovf = 0.
- Add with back-pressure: four accepts of a=3, b=2, m=0 and `out_ready` = 0 for 3 cycles → out = 20 held stable, `in_ready` = 0 until `out_ready` = 1.
- Overflow:
  - `ACC_WIDTH` = 5, four accepts of a=3, b=3, m=1.
  - Without the macro: out = 4, ovf = 1.
  - With `DSP_MAC_SATURATE_EN`: out = 31, ovf = 1.
- Overlap: `out_ready` = 1 continuously, eight consecutive accepts of a=1, b=2, m=1 → two results of 8 each, with no idle cycle between them.
- `clr`:
  - Two accepts of a=2, b=2, m=1, then `clr` together with an accept of a=1, b=1, m=1, then three more accepts of a=1, b=1, m=1.
  - Result: out = 4.
- Reset mid-operation: `rst_n` low for 1 cycle after two accepts → `out_valid` = 0, out = 0, ovf = 0; the next four accepts of a=1, b=1, m=0 give out = 8.

Source files
------------

// File: rtl/dsp_mac_pkg.sv
// Shared types and constants for the dsp_mac_out_registered slice.
package dsp_mac_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam logic DSP_MODE_ADD = 1'b0;
  localparam logic DSP_MODE_MUL = 1'b1;

  // Bits needed to hold a term count in 0..len.
  function automatic int unsigned cnt_width(input int unsigned len);
    int unsigned w;
    w = 1;
    while ((64'd1 << w) < (64'(len) + 64'd1)) w++;
    return w;
  endfunction

endpackage

// File: rtl/dsp_mac_term.sv
// Combinational term generator: term = m ? a*b : a+b, unsigned at DATA_WIDTH bits.
module dsp_mac_term
  import dsp_mac_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 4
) (
  input  logic [DATA_WIDTH/2-1:0] a,
  input  logic [DATA_WIDTH/2-1:0] b,
  input  logic                    m,
  output logic [DATA_WIDTH-1:0]   term
);

  localparam int unsigned HW = DATA_WIDTH / 2;

  logic [DATA_WIDTH-1:0] w_a_ext;
  logic [DATA_WIDTH-1:0] w_b_ext;

  assign w_a_ext = {{(DATA_WIDTH - HW){1'b0}}, a};
  assign w_b_ext = {{(DATA_WIDTH - HW){1'b0}}, b};

  always_comb begin
    if (m == DSP_MODE_MUL) term = w_a_ext * w_b_ext;
    else                   term = w_a_ext + w_b_ext;
  end

endmodule

// File: rtl/dsp_mac_out_registered.sv
// Accumulates ACC_LEN handshaked terms and presents the sum from an output register.
// Optional DSP_MAC_SATURATE_EN: accumulator clamps at all-ones instead of wrapping.
module dsp_mac_out_registered
  import dsp_mac_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned ACC_WIDTH  = 8,
  parameter int unsigned ACC_LEN    = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH/2-1:0] a,
  input  logic [DATA_WIDTH/2-1:0] b,
  input  logic                    m,
  input  logic                    clr,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ACC_WIDTH-1:0]    out,
  output logic                    ovf
);

  localparam int unsigned    CW   = cnt_width(ACC_LEN);
  localparam logic [CW-1:0]  LAST = CW'(ACC_LEN - 1);

  state_t                r_state, w_state_nxt;
  logic [ACC_WIDTH-1:0]  r_acc, w_acc_nxt;
  logic [CW-1:0]         r_count, w_count_nxt;
  logic                  r_sticky, w_sticky_nxt;
  logic [ACC_WIDTH-1:0]  r_out, w_out_nxt;
  logic                  r_ovf, w_ovf_nxt;
  logic                  r_out_valid, w_out_valid_nxt;

  logic [DATA_WIDTH-1:0] w_term;
  logic                  w_accept;
  logic [ACC_WIDTH-1:0]  w_base_acc;
  logic [CW-1:0]         w_base_count;
  logic                  w_base_sticky;
  logic [ACC_WIDTH:0]    w_sum;
  logic                  w_carry;
  logic [ACC_WIDTH-1:0]  w_acc_add;
  logic                  w_last;

  dsp_mac_term #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_term (
    .a    (a),
    .b    (b),
    .m    (m),
    .term (w_term)
  );

  assign in_ready = rst_n && ((r_state == ACCUM) || out_ready);
  assign w_accept = in_valid && in_ready;

  // clr discards the partial sum before this cycle's term is added, so a
  // simultaneous accept starts a fresh accumulation from the term alone.
  assign w_base_acc    = clr ? '0   : r_acc;
  assign w_base_count  = clr ? '0   : r_count;
  assign w_base_sticky = clr ? 1'b0 : r_sticky;

  assign w_sum   = {1'b0, w_base_acc} + {{(ACC_WIDTH + 1 - DATA_WIDTH){1'b0}}, w_term};
  assign w_carry = w_sum[ACC_WIDTH];
  assign w_last  = (w_base_count == LAST);

`ifdef DSP_MAC_SATURATE_EN
  assign w_acc_add = w_carry ? '1 : w_sum[ACC_WIDTH-1:0];
`else
  assign w_acc_add = w_sum[ACC_WIDTH-1:0];
`endif

  always_comb begin
    w_state_nxt     = r_state;
    w_acc_nxt       = r_acc;
    w_count_nxt     = r_count;
    w_sticky_nxt    = r_sticky;
    w_out_nxt       = r_out;
    w_ovf_nxt       = r_ovf;
    w_out_valid_nxt = r_out_valid;

    if (clr) begin
      w_acc_nxt    = '0;
      w_count_nxt  = '0;
      w_sticky_nxt = 1'b0;
    end

    if ((r_state == HOLD) && out_ready) begin
      w_state_nxt     = ACCUM;
      w_out_valid_nxt = 1'b0;
    end

    // Acc is always zero while in HOLD, so an accept on the consuming cycle
    // naturally starts the next result with acc = term, count = 1.
    if (w_accept) begin
      if (w_last) begin
        w_out_nxt       = w_acc_add;
        w_ovf_nxt       = w_base_sticky | w_carry;
        w_out_valid_nxt = 1'b1;
        w_state_nxt     = HOLD;
        w_acc_nxt       = '0;
        w_count_nxt     = '0;
        w_sticky_nxt    = 1'b0;
      end else begin
        w_acc_nxt    = w_acc_add;
        w_count_nxt  = w_base_count + 1'b1;
        w_sticky_nxt = w_base_sticky | w_carry;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ACCUM;
      r_acc       <= '0;
      r_count     <= '0;
      r_sticky    <= 1'b0;
      r_out       <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_acc       <= w_acc_nxt;
      r_count     <= w_count_nxt;
      r_sticky    <= w_sticky_nxt;
      r_out       <= w_out_nxt;
      r_ovf       <= w_ovf_nxt;
      r_out_valid <= w_out_valid_nxt;
    end
  end

  assign out       = r_out;
  assign ovf       = r_ovf;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_dsp_mac_out_registered.sv
// Bench for dsp_mac_out_registered: default instance plus an ACC_WIDTH=5 instance.
module tb_dsp_mac_out_registered;

  localparam int unsigned LEN = 4;
`ifdef DSP_MAC_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, in_valid, m, clr, out_ready;
  logic [1:0] a, b;
  logic       in_ready, out_valid, ovf;
  logic [7:0] out;
  logic       in_ready5, out_valid5, ovf5;
  logic [4:0] out5;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  bit          m_hold [2];
  bit          m_ovf  [2];
  int unsigned m_cnt  [2];
  int unsigned m_sum  [2];
  int unsigned m_out  [2];

  always #5 clk = ~clk;

  dsp_mac_out_registered dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .m(m), .clr(clr), .out_valid(out_valid),
    .out_ready(out_ready), .out(out), .ovf(ovf)
  );

  dsp_mac_out_registered #(
    .DATA_WIDTH(4), .ACC_WIDTH(5), .ACC_LEN(4)
  ) dut5 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready5),
    .a(a), .b(b), .m(m), .clr(clr), .out_valid(out_valid5),
    .out_ready(out_ready), .out(out5), .ovf(ovf5)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: a group of LEN accepted terms yields its true sum, reduced
  // modulo 2^w (or clamped to 2^w-1), and ovf iff the true sum reached 2^w.
  task automatic model_edge(input int k, input int unsigned w);
    bit          rdy;
    int unsigned lim;
    rdy = rst_n && (!m_hold[k] || out_ready);
    lim = 32'd1 << w;
    if (!rst_n) begin
      m_hold[k] = 0; m_ovf[k] = 0; m_cnt[k] = 0; m_sum[k] = 0; m_out[k] = 0;
    end else begin
      if (clr) begin
        m_cnt[k] = 0; m_sum[k] = 0;
      end
      if (m_hold[k] && out_ready) m_hold[k] = 0;
      if (in_valid && rdy) begin
        m_sum[k] += m ? 32'(a) * 32'(b) : 32'(a) + 32'(b);
        m_cnt[k]++;
        if (m_cnt[k] == LEN) begin
          m_ovf[k]  = (m_sum[k] >= lim);
          m_out[k]  = !m_ovf[k] ? m_sum[k] : (SAT ? lim - 1 : m_sum[k] % lim);
          m_hold[k] = 1;
          m_cnt[k]  = 0;
          m_sum[k]  = 0;
        end
      end
    end
  endtask

  task automatic cycle(input int unsigned v, ia, ib, im, iclr, iordy, irst);
    @(negedge clk);
    in_valid  = 1'(v);
    a         = 2'(ia);
    b         = 2'(ib);
    m         = 1'(im);
    clr       = 1'(iclr);
    out_ready = 1'(iordy);
    rst_n     = 1'(irst);
    #1;
    check("in_ready",  32'(in_ready),  32'(rst_n && (!m_hold[0] || out_ready)));
    check("in_ready5", 32'(in_ready5), 32'(rst_n && (!m_hold[1] || out_ready)));
    @(posedge clk);
    model_edge(0, 8);
    model_edge(1, 5);
    #1;
    check("out_valid",  32'(out_valid),  32'(m_hold[0]));
    check("out",        32'(out),        m_out[0]);
    check("ovf",        32'(ovf),        32'(m_ovf[0]));
    check("out_valid5", 32'(out_valid5), 32'(m_hold[1]));
    check("out5",       32'(out5),       m_out[1]);
    check("ovf5",       32'(ovf5),       32'(m_ovf[1]));
  endtask

  initial begin
    rst_n = 0; in_valid = 0; a = 0; b = 0; m = 0; clr = 0; out_ready = 0;
    cycle(0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);

    // multiply 3*3 four times; narrow instance overflows
    for (int i = 0; i < 4; i++) begin
      if (i == 3) check("mul_not_early", 32'(out_valid), 32'd0);
      cycle(1, 3, 3, 1, 0, 1, 1);
    end
    check("mul_valid", 32'(out_valid), 32'd1);
    check("mul_out",   32'(out),       32'd36);
    check("mul_ovf",   32'(ovf),       32'd0);
    check("ovf5_out",  32'(out5),      SAT ? 32'd31 : 32'd4);
    check("ovf5_flag", 32'(ovf5),      32'd1);
    cycle(0, 0, 0, 0, 0, 1, 1);

    // add with back-pressure
    for (int i = 0; i < 4; i++) cycle(1, 3, 2, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 1, 1, 1, 0, 0, 1);
      check("bp_out",   32'(out),      32'd20);
      check("bp_valid", 32'(out_valid), 32'd1);
    end
    cycle(0, 0, 0, 0, 0, 1, 1);

    // back-to-back results with no idle cycle
    for (int i = 0; i < 8; i++) begin
      cycle(1, 1, 2, 1, 0, 1, 1);
      if (i == 3 || i == 7) check("ovl_out", 32'(out), 32'd8);
    end
    cycle(0, 0, 0, 0, 0, 1, 1);

    // clr together with an accept restarts the accumulation
    cycle(1, 2, 2, 1, 0, 1, 1);
    cycle(1, 2, 2, 1, 0, 1, 1);
    cycle(1, 1, 1, 1, 1, 1, 1);
    for (int i = 0; i < 3; i++) cycle(1, 1, 1, 1, 0, 1, 1);
    check("clr_out", 32'(out), 32'd4);
    cycle(0, 0, 0, 0, 0, 1, 1);

    // reset mid-operation
    cycle(1, 1, 1, 0, 0, 1, 1);
    cycle(1, 1, 1, 0, 0, 1, 1);
    cycle(1, 1, 1, 0, 0, 1, 0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_out",   32'(out),       32'd0);
    for (int i = 0; i < 4; i++) cycle(1, 1, 1, 0, 0, 1, 1);
    check("rst_after_out", 32'(out), 32'd8);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 3) != 0 ? 1 : 0, $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 1), $urandom_range(0, 11) == 0 ? 1 : 0,
            $urandom_range(0, 2) != 0 ? 1 : 0, $urandom_range(0, 79) != 0 ? 1 : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
